// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU debug/trace blocks: trace FSM encodings and
// the layout of one retired-instruction record.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_TRIG   = 2'd2,
    ST_FROZEN = 2'd3
  } trace_state_e;

  localparam int PC_W  = 32;
  localparam int IR_W  = 32;
  localparam int CTL_W = 4;
  localparam int Y_W   = 32;
  localparam int REC_W = PC_W + IR_W + CTL_W + Y_W;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [IR_W-1:0]  ir;
    logic [CTL_W-1:0] ctl;
    logic [Y_W-1:0]   y;
  } trace_rec_t;

endpackage

// File: rtl/trace_ram.sv
// Trace record storage: synchronous write, asynchronous read, so it maps onto
// distributed RAM and gives the debug unit a zero-latency indexed read.
module trace_ram
  import cpu_dbg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_cpu,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [REC_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [REC_W-1:0] rdata_o
);

  logic [REC_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_cpu) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular instruction-trace recorder behind the single-cycle RV32 core, with
// arm/disarm control, PC-match trigger, post-trigger window and freeze.
module cpu_trace_buffer
  import cpu_dbg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_cpu,
  input  logic          rstn,
  input  logic          arm,
  input  logic          disarm,
  input  logic [31:0]   pc_in,
  input  logic [31:0]   ir_in,
  input  logic [3:0]    ctl_in,
  input  logic [31:0]   y_in,
  input  logic          trig_en,
  input  logic [31:0]   trig_pc,
  input  logic [AW-1:0] post_cnt,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_pc,
  output logic [31:0]   rd_ir,
  output logic [3:0]    rd_ctl,
  output logic [31:0]   rd_y,
  output logic [AW:0]   count,
  output logic [1:0]    state,
  output logic          wrapped,
  output logic [AW-1:0] trig_idx
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  trace_state_e  state_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wrapped_q;
  logic [AW-1:0] post_left_q;
  logic [AW-1:0] post_lat_q;
  logic [AW-1:0] trig_idx_q;

  logic          capture;
  logic          hit;
  trace_rec_t    wr_rec;
  trace_rec_t    rd_rec;
  logic [AW-1:0] rd_phys;
  logic          rd_valid;

  // Trigger record position once the window closes; clamps at 0 if it was overwritten.
  function automatic logic [AW-1:0] calc_trig_idx(input logic [AW:0] n, input logic [AW-1:0] post);
    logic [AW:0] span;
    span = {1'b0, post} + (AW+1)'(1);
    if (n >= span) return AW'(n - span);
    else           return '0;
  endfunction

  assign capture = !disarm && !arm && (state_q == ST_ARMED || state_q == ST_TRIG);
  assign hit     = trig_en && (pc_in == trig_pc);
  assign wr_ptr_d = wr_ptr_q + AW'(1);
  assign count_d  = (count_q == DEPTH_C) ? count_q : count_q + (AW+1)'(1);
  assign wr_rec   = '{pc: pc_in, ir: ir_in, ctl: ctl_in, y: y_in};

  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wrapped_q   <= 1'b0;
      post_left_q <= '0;
      post_lat_q  <= '0;
      trig_idx_q  <= '0;
    end else if (disarm) begin
      state_q <= ST_IDLE;
    end else if (arm) begin
      state_q     <= ST_ARMED;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wrapped_q   <= 1'b0;
      post_left_q <= '0;
    end else if (capture) begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (count_q == DEPTH_C) wrapped_q <= 1'b1;
      if (state_q == ST_ARMED) begin
        if (hit) begin
          if (post_cnt == '0) begin
            state_q    <= ST_FROZEN;
            trig_idx_q <= calc_trig_idx(count_d, '0);
          end else begin
            state_q     <= ST_TRIG;
            post_left_q <= post_cnt;
            post_lat_q  <= post_cnt;
          end
        end
      end else begin
        post_left_q <= post_left_q - AW'(1);
        if (post_left_q == AW'(1)) begin
          state_q    <= ST_FROZEN;
          trig_idx_q <= calc_trig_idx(count_d, post_lat_q);
        end
      end
    end
  end

  // Logical index 0 is the oldest record, which sits count entries behind the write pointer.
  assign rd_phys  = wr_ptr_q - count_q[AW-1:0] + rd_idx;
  assign rd_valid = ({1'b0, rd_idx} < count_q);

  logic [REC_W-1:0] ram_rdata;

  trace_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_cpu (clk_cpu),
    .we_i    (capture),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_rec),
    .raddr_i (rd_phys),
    .rdata_o (ram_rdata)
  );

  assign rd_rec   = rd_valid ? trace_rec_t'(ram_rdata) : '0;
  assign rd_pc    = rd_rec.pc;
  assign rd_ir    = rd_rec.ir;
  assign rd_ctl   = rd_rec.ctl;
  assign rd_y     = rd_rec.y;
  assign count    = count_q;
  assign state    = state_q;
  assign wrapped  = wrapped_q;
  assign trig_idx = trig_idx_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: a queue model of the trace history
// is updated as records are driven and popped against the indexed read port.
module tb_cpu_trace_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk_cpu = 1'b0;
  logic          rstn    = 1'b0;
  logic          arm     = 1'b0;
  logic          disarm  = 1'b0;
  logic [31:0]   pc_in   = '0;
  logic [31:0]   ir_in   = '0;
  logic [3:0]    ctl_in  = '0;
  logic [31:0]   y_in    = '0;
  logic          trig_en = 1'b0;
  logic [31:0]   trig_pc = '0;
  logic [AW-1:0] post_cnt = '0;
  logic [AW-1:0] rd_idx   = '0;
  logic [31:0]   rd_pc, rd_ir, rd_y;
  logic [3:0]    rd_ctl;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic          wrapped;
  logic [AW-1:0] trig_idx;

  cpu_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_cpu  (clk_cpu),
    .rstn     (rstn),
    .arm      (arm),
    .disarm   (disarm),
    .pc_in    (pc_in),
    .ir_in    (ir_in),
    .ctl_in   (ctl_in),
    .y_in     (y_in),
    .trig_en  (trig_en),
    .trig_pc  (trig_pc),
    .post_cnt (post_cnt),
    .rd_idx   (rd_idx),
    .rd_pc    (rd_pc),
    .rd_ir    (rd_ir),
    .rd_ctl   (rd_ctl),
    .rd_y     (rd_y),
    .count    (count),
    .state    (state),
    .wrapped  (wrapped),
    .trig_idx (trig_idx)
  );

  always #50 clk_cpu = ~clk_cpu;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [3:0]  ctl;
    logic [31:0] y;
  } rec_t;

  rec_t modelQ[$];
  int   mState    = 0;
  int   mWrapped  = 0;
  int   mTrigIdx  = 0;
  int   mPostLeft = 0;
  int   mPostLat  = 0;
  int   numCompared   = 0;
  int   numMismatched = 0;

  function automatic rec_t mkRec(input logic [31:0] pc);
    rec_t r;
    r.pc  = pc;
    r.ir  = {pc[15:0], 16'h0013};
    r.ctl = pc[5:2];
    r.y   = pc * 3 + 32'h11;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one clock edge and advance the reference model with the same inputs.
  task automatic applyStimulus(input logic doArm, input logic doDisarm, input logic [31:0] pc);
    rec_t r;
    r = mkRec(pc);
    @(negedge clk_cpu);
    arm    = doArm;
    disarm = doDisarm;
    pc_in  = r.pc;
    ir_in  = r.ir;
    ctl_in = r.ctl;
    y_in   = r.y;
    if (doDisarm) begin
      mState = 0;
    end else if (doArm) begin
      mState = 1;
      modelQ.delete();
      mWrapped  = 0;
      mPostLeft = 0;
    end else if (mState == 1 || mState == 2) begin
      modelQ.push_back(r);
      if (modelQ.size() > DEPTH) begin
        void'(modelQ.pop_front());
        mWrapped = 1;
      end
      if (mState == 1) begin
        if (trig_en && pc == trig_pc) begin
          if (post_cnt == 0) begin
            mState   = 3;
            mTrigIdx = modelQ.size() - 1;
          end else begin
            mState    = 2;
            mPostLeft = int'(post_cnt);
            mPostLat  = int'(post_cnt);
          end
        end
      end else begin
        if (mPostLeft == 1) begin
          mState   = 3;
          mTrigIdx = modelQ.size() - 1 - mPostLat;
          if (mTrigIdx < 0) mTrigIdx = 0;
        end
        mPostLeft--;
      end
    end
    @(posedge clk_cpu);
    #1;
    arm    = 1'b0;
    disarm = 1'b0;
  endtask

  task automatic verifyAll(input string tag);
    rec_t expQ[$];
    rec_t e;
    checkOutput({tag, ".state"},   32'(state),   32'(mState));
    checkOutput({tag, ".count"},   32'(count),   32'(modelQ.size()));
    checkOutput({tag, ".wrapped"}, 32'(wrapped), 32'(mWrapped));
    if (mState == 3) checkOutput({tag, ".trig_idx"}, 32'(trig_idx), 32'(mTrigIdx));
    expQ = modelQ;
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = AW'(i);
      #1;
      e = (expQ.size() > 0) ? expQ.pop_front() : '0;
      checkOutput($sformatf("%s.pc[%0d]", tag, i),  rd_pc,         e.pc);
      checkOutput($sformatf("%s.ir[%0d]", tag, i),  rd_ir,         e.ir);
      checkOutput($sformatf("%s.ctl[%0d]", tag, i), 32'(rd_ctl),   32'(e.ctl));
      checkOutput($sformatf("%s.y[%0d]", tag, i),   rd_y,          e.y);
    end
  endtask

  task automatic runPcs(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h3000 + 32'(4 * k));
      checkOutput($sformatf("%s.state@%0d", tag, k), 32'(state), 32'(mState));
    end
  endtask

  initial begin
    $display("[TB] start");
    rstn = 1'b0;
    repeat (2) @(negedge clk_cpu);
    rstn = 1'b1;

    // Idle after reset: nothing recorded, reads all zero.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 32'h1000 + 32'(4 * k));
    verifyAll("idle");

    // Simple capture of five records.
    applyStimulus(1'b1, 1'b0, 32'h0);
    runPcs(5, "cap5");
    verifyAll("cap5");
    checkOutput("cap5.count_const", 32'(count), 32'd5);

    // Wrap: 20 records into 16 slots.
    applyStimulus(1'b1, 1'b0, 32'h0);
    runPcs(20, "wrap");
    verifyAll("wrap");
    rd_idx = 0;  #1; checkOutput("wrap.oldest_pc", rd_pc, 32'h3010);
    rd_idx = 15; #1; checkOutput("wrap.newest_pc", rd_pc, 32'h304C);

    // Trigger with a 3-record post window; post_cnt and trig_pc changed mid-window.
    trig_en = 1'b1; trig_pc = 32'h3020; post_cnt = 4'd3;
    applyStimulus(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h3000 + 32'(4 * k));
      checkOutput($sformatf("trig.state@%0d", k), 32'(state), 32'(mState));
      if (k == 9) begin
        post_cnt = 4'd7;
        trig_pc  = 32'h3028;
      end
    end
    verifyAll("trig");
    checkOutput("trig.count_const", 32'(count),    32'd12);
    checkOutput("trig.idx_const",   32'(trig_idx), 32'd8);

    // Immediate freeze with post_cnt = 0.
    trig_pc = 32'h3008; post_cnt = 4'd0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    runPcs(6, "post0");
    verifyAll("post0");
    rd_idx = 2; #1; checkOutput("post0.trig_pc", rd_pc, 32'h3008);

    // Post window overruns capacity: wraps, trigger record survives at index 5.
    trig_pc = 32'h3028; post_cnt = 4'd10;
    applyStimulus(1'b1, 1'b0, 32'h0);
    runPcs(25, "ovr");
    verifyAll("ovr");
    checkOutput("ovr.idx_const", 32'(trig_idx), 32'd5);

    // arm and disarm together: disarm wins, contents retained.
    trig_en = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    runPcs(3, "both");
    applyStimulus(1'b1, 1'b1, 32'h5000);
    verifyAll("both");
    for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b0, 32'h6000 + 32'(4 * k));
    verifyAll("both_idle");

    // Asynchronous reset in the middle of a post-trigger window.
    trig_en = 1'b1; trig_pc = 32'h3040; post_cnt = 4'd8;
    applyStimulus(1'b1, 1'b0, 32'h0);
    runPcs(19, "rst");
    checkOutput("rst.pre_state",   32'(state),   32'd2);
    checkOutput("rst.pre_wrapped", 32'(wrapped), 32'd1);
    @(negedge clk_cpu);
    #5;
    rstn = 1'b0;
    #2;
    modelQ.delete();
    mState = 0; mWrapped = 0; mTrigIdx = 0; mPostLeft = 0;
    checkOutput("rst.state",   32'(state),   32'd0);
    checkOutput("rst.count",   32'(count),   32'd0);
    checkOutput("rst.wrapped", 32'(wrapped), 32'd0);
    @(negedge clk_cpu);
    rstn = 1'b1;
    trig_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h7000);
    verifyAll("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
